// File: rtl/palette_reader_if.sv
// Video, palette-port and CPU read-back signals of the palette reader.
// The reader is the slave; the timing/fetch logic, palette RAM and CPU form the master side.
interface palette_reader_if #(
  parameter int ADDR_W = 16
);
  logic              blank_in;
  logic              border_in;
  logic [7:0]        pix_index;
  logic [7:0]        border_idx;
  logic              hsync_in;
  logic              vsync_in;
  logic [ADDR_W-1:0] pal_addr;
  logic [15:0]       pal_data;
  logic [15:0]       rgb;
  logic              de_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              cpu_rd_req;
  logic [7:0]        cpu_rd_addr;
  logic              cpu_rd_ack;
  logic [15:0]       cpu_rd_data;

  modport master (
    output blank_in, border_in, pix_index, border_idx, hsync_in, vsync_in,
    output pal_data, cpu_rd_req, cpu_rd_addr,
    input  pal_addr, rgb, de_out, hsync_out, vsync_out, cpu_rd_ack, cpu_rd_data
  );

  modport slave (
    input  blank_in, border_in, pix_index, border_idx, hsync_in, vsync_in,
    input  pal_data, cpu_rd_req, cpu_rd_addr,
    output pal_addr, rgb, de_out, hsync_out, vsync_out, cpu_rd_ack, cpu_rd_data
  );
endinterface

// File: rtl/palette_reader.sv
// Palette reader: pixel/border index -> palette colour, plus CPU read-back served in blanking.
// Latency: video 3 clocks, CPU ack 3 clocks after issue. No backpressure: one pixel per clock;
// CPU reads wait for blanking and are held off by a four-phase req/ack handshake.
module palette_reader #(
  parameter int          ADDR_W      = 16,
  parameter logic [15:0] BLANK_COLOR = 16'h0000,
  parameter logic        SYNC_RESET  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  palette_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ack_q, ack_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              issue;

  // Tag stages 1 and 2; the output registers form stage 3.
  logic [1:0]        blank_q, hs_q, vs_q;
  logic [15:0]       rgb_q;
  logic              de_q, hso_q, vso_q;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_rd_req && bus.blank_in) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        state_d = HOLD;
        ack_d   = 1'b1;
        rdata_d = bus.pal_data;
      end
      HOLD: begin
        if (!bus.cpu_rd_req) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The CPU only borrows the port in blanking, so the video path never loses a slot.
  always_comb begin
    addr_d = addr_q;
    if (issue) begin
      addr_d = ADDR_W'(bus.cpu_rd_addr);
    end else if (!bus.blank_in) begin
      addr_d = ADDR_W'(bus.border_in ? bus.border_idx : bus.pix_index);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      blank_q <= 2'b11;
      hs_q    <= {2{SYNC_RESET}};
      vs_q    <= {2{SYNC_RESET}};
      rgb_q   <= BLANK_COLOR;
      de_q    <= 1'b0;
      hso_q   <= SYNC_RESET;
      vso_q   <= SYNC_RESET;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      blank_q <= {blank_q[0], bus.blank_in};
      hs_q    <= {hs_q[0], bus.hsync_in};
      vs_q    <= {vs_q[0], bus.vsync_in};
      rgb_q   <= blank_q[1] ? BLANK_COLOR : bus.pal_data;
      de_q    <= ~blank_q[1];
      hso_q   <= hs_q[1];
      vso_q   <= vs_q[1];
    end
  end

  assign bus.pal_addr    = addr_q;
  assign bus.rgb         = rgb_q;
  assign bus.de_out      = de_q;
  assign bus.hsync_out   = hso_q;
  assign bus.vsync_out   = vso_q;
  assign bus.cpu_rd_ack  = ack_q;
  assign bus.cpu_rd_data = rdata_q;

endmodule

// File: tb/tb_palette_reader.sv
// Bench for palette_reader: palette RAM model, directed scenarios, then random video and CPU traffic
// scored against a queue-based reference model.
module tb_palette_reader;
  localparam int          ADDR_W      = 16;
  localparam logic [15:0] BLANK_COLOR = 16'h0000;
  localparam logic        SYNC_RESET  = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  palette_reader_if #(.ADDR_W(ADDR_W)) bus ();

  palette_reader #(
    .ADDR_W(ADDR_W), .BLANK_COLOR(BLANK_COLOR), .SYNC_RESET(SYNC_RESET)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  logic [15:0] mem [256];
  initial for (int k = 0; k < 256; k++) mem[k] = {8'(k), ~8'(k)};
  initial bus.pal_data = 16'h0;
  always @(posedge clk) bus.pal_data <= mem[bus.pal_addr[7:0]];

  typedef struct {
    logic [15:0] rgb;
    logic        de, hs, vs;
    int          due;
  } vexp_t;

  vexp_t vq[$];
  vexp_t v_new, v_got;
  int    edges = 0;
  int    checks = 0;
  int    errors = 0;

  // Reference model: expected port state in terms of the behavioural rules.
  logic [ADDR_W-1:0] m_addr;
  logic              m_busy, m_ack;
  logic [15:0]       m_data;
  logic [7:0]        m_cpu_addr;
  int                m_issue_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    edges++;
    if (rst) begin
      vq.delete();
      m_addr = '0;
      m_busy = 1'b0;
      m_ack  = 1'b0;
      m_data = 16'h0;
    end else begin
      v_new.rgb = bus.blank_in ? BLANK_COLOR
                               : mem[bus.border_in ? bus.border_idx : bus.pix_index];
      v_new.de  = !bus.blank_in;
      v_new.hs  = bus.hsync_in;
      v_new.vs  = bus.vsync_in;
      v_new.due = edges + 2;
      vq.push_back(v_new);
      if (!m_busy && bus.cpu_rd_req && bus.blank_in) begin
        m_busy     = 1'b1;
        m_issue_e  = edges;
        m_cpu_addr = bus.cpu_rd_addr;
        m_addr     = ADDR_W'(bus.cpu_rd_addr);
      end else begin
        if (m_busy && edges == m_issue_e + 2) begin
          m_ack  = 1'b1;
          m_data = mem[m_cpu_addr];
        end else if (m_busy && edges >= m_issue_e + 3 && !bus.cpu_rd_req) begin
          m_busy = 1'b0;
          m_ack  = 1'b0;
        end
        if (!bus.blank_in)
          m_addr = ADDR_W'(bus.border_in ? bus.border_idx : bus.pix_index);
      end
    end
  end

  // Monitor: video output is valid every cycle; pop whichever expectation falls due now.
  always @(negedge clk) begin
    if (!rst) begin
      chk("pal_addr", 32'(bus.pal_addr), 32'(m_addr));
      chk("cpu_rd_ack", 32'(bus.cpu_rd_ack), 32'(m_ack));
      chk("cpu_rd_data", 32'(bus.cpu_rd_data), 32'(m_data));
      if (vq.size() > 0 && vq[0].due == edges) begin
        v_got = vq.pop_front();
        chk("rgb", 32'(bus.rgb), 32'(v_got.rgb));
        chk("de_out", 32'(bus.de_out), 32'(v_got.de));
        chk("hsync_out", 32'(bus.hsync_out), 32'(v_got.hs));
        chk("vsync_out", 32'(bus.vsync_out), 32'(v_got.vs));
      end
    end
  end

  task automatic drive(input logic b, input logic bo, input logic [7:0] p,
                       input logic [7:0] bi, input logic h, input logic v);
    @(negedge clk);
    bus.blank_in   = b;
    bus.border_in  = bo;
    bus.pix_index  = p;
    bus.border_idx = bi;
    bus.hsync_in   = h;
    bus.vsync_in   = v;
  endtask

  task automatic wait_ack(input logic blk, output int n);
    n = 0;
    while (!bus.cpu_rd_ack && n < 20) begin
      drive(blk, 1'b0, 8'($urandom), 8'h10, 1'b0, 1'b0);
      n++;
    end
  endtask

  logic rb, rbo;
  int   n;

  initial begin
    bus.blank_in = 1'b1; bus.border_in = 1'b0; bus.pix_index = 8'h0; bus.border_idx = 8'h0;
    bus.hsync_in = 1'b1; bus.vsync_in = 1'b1; bus.cpu_rd_req = 1'b0; bus.cpu_rd_addr = 8'h0;

    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'(bus.rgb), 32'(BLANK_COLOR));
    chk("rst_de", 32'(bus.de_out), 32'(1'b0));
    chk("rst_hsync", 32'(bus.hsync_out), 32'(SYNC_RESET));
    chk("rst_vsync", 32'(bus.vsync_out), 32'(SYNC_RESET));
    chk("rst_ack", 32'(bus.cpu_rd_ack), 32'(1'b0));
    chk("rst_addr", 32'(bus.pal_addr), 32'(0));
    rst = 1'b0;

    // Active pixels, border run, then blanking.
    repeat (3) drive(1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h01, 8'h10, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'hFF, 8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'($urandom), 8'h10, 1'(i), 1'b1);
    repeat (4) drive(1'b1, 1'b0, 8'h33, 8'h10, 1'b1, 1'b0);

    // CPU read during blanking.
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 8'h42;
    wait_ack(1'b1, n);
    chk("ack_lat_42", 32'(n), 32'd3);
    chk("data_42", 32'(bus.cpu_rd_data), 32'h42BD);
    bus.cpu_rd_req = 1'b0;
    drive(1'b1, 1'b0, 8'h0, 8'h10, 1'b0, 1'b0);
    chk("ack_drop_42", 32'(bus.cpu_rd_ack), 32'd0);
    chk("data_hold_42", 32'(bus.cpu_rd_data), 32'h42BD);
    drive(1'b1, 1'b0, 8'h0, 8'h10, 1'b0, 1'b0);

    // Request during active video waits; blanking lasts only the issue cycle.
    drive(1'b0, 1'b0, 8'h21, 8'h10, 1'b0, 1'b0);
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 8'h07;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'($urandom), 8'h10, 1'b0, 1'b0);
      chk("no_ack_active", 32'(bus.cpu_rd_ack), 32'd0);
    end
    drive(1'b1, 1'b0, 8'h00, 8'h10, 1'b1, 1'b0);
    wait_ack(1'b0, n);
    chk("ack_lat_07", 32'(n), 32'd3);
    chk("data_07", 32'(bus.cpu_rd_data), 32'h07F8);
    bus.cpu_rd_req = 1'b0;
    drive(1'b0, 1'b0, 8'h5A, 8'h10, 1'b0, 1'b0);
    chk("ack_drop_07", 32'(bus.cpu_rd_ack), 32'd0);

    // Reset while the read is in WAIT.
    repeat (2) drive(1'b1, 1'b0, 8'h0, 8'h10, 1'b0, 1'b0);
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 8'h55;
    repeat (2) drive(1'b1, 1'b0, 8'h0, 8'h10, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("wrst_ack", 32'(bus.cpu_rd_ack), 32'd0);
    chk("wrst_rgb", 32'(bus.rgb), 32'(BLANK_COLOR));
    chk("wrst_de", 32'(bus.de_out), 32'd0);
    chk("wrst_hsync", 32'(bus.hsync_out), 32'(SYNC_RESET));
    chk("wrst_vsync", 32'(bus.vsync_out), 32'(SYNC_RESET));
    chk("wrst_data", 32'(bus.cpu_rd_data), 32'd0);
    bus.cpu_rd_req = 1'b0;
    repeat (2) drive(1'b1, 1'b0, 8'h0, 8'h10, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 8'h0, 8'h10, 1'b0, 1'b0);
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 8'h99;
    wait_ack(1'b1, n);
    chk("ack_lat_99", 32'(n), 32'd3);
    chk("data_99", 32'(bus.cpu_rd_data), 32'h9966);
    bus.cpu_rd_req = 1'b0;
    drive(1'b1, 1'b0, 8'h0, 8'h10, 1'b0, 1'b0);

    // Random video with a four-phase CPU agent.
    rb = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) rb = ~rb;
      rbo = ($urandom_range(3) == 0);
      drive(rb, rbo, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if (!bus.cpu_rd_req && !bus.cpu_rd_ack && $urandom_range(5) == 0) begin
        bus.cpu_rd_addr = 8'($urandom);
        bus.cpu_rd_req  = 1'b1;
      end else if (bus.cpu_rd_req && bus.cpu_rd_ack && $urandom_range(2) == 0) begin
        bus.cpu_rd_req = 1'b0;
      end
    end
    bus.cpu_rd_req = 1'b0;
    repeat (10) drive(1'b1, 1'b0, 8'h0, 8'h10, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
